key_debounce_fsm: RTL and testbench
===================================

Name: key_debounce_fsm

Overview:
- Downstream consumer of the key edge detector's H2L_Sig/L2H_Sig pulses.
- Applies a 10 ms lockout after each detected edge.
- Confirms the edge against the synchronised pin level and issues clean one-cycle press/release/long-press pulses plus a debounced key level.
- Outputs feed application logic (LED toggles, counters, menus).

Parameters:
T_LOCK, 19'd499_999, lockout length minus 1 in CLK cycles (10 ms at 50 MHz)
T_LONG, 26'd49_999_999, hold time minus 1 for long-press (1 s at 50 MHz)

Ports:
CLK  input  1  system clock, 50 MHz
RST  input  1  reset, asynchronous, active-high
H2L_Sig  input  1  one-cycle falling-edge pulse from the edge detector
L2H_Sig  input  1  one-cycle rising-edge pulse from the edge detector
Pin_In  input  1  raw key pin, active-low pressed
Key_Press  output  1  one-cycle pulse on confirmed press
Key_Release  output  1  one-cycle pulse on confirmed release
Key_Long  output  1  one-cycle pulse, once per press, when hold reaches T_LONG
Key_Level  output  1  debounced level, 1 = pressed

Behaviour:
- Reset (RST high, asynchronous): state=IDLE, both counters=0, sync flops=1, Key_Press/Key_Release/Key_Long/Key_Level=0.
- Pin_In passes through a 2-flop synchroniser reset to 1. Its output is pin_s.
- All outputs are registered.
- States: IDLE, LOCK_DN, DOWN, LOCK_UP.
- IDLE:
  - H2L_Sig=1 -> LOCK_DN, lock counter cleared to 0.
  - L2H_Sig is ignored.
- LOCK_DN:
  - Lock counter increments each cycle. H2L/L2H are ignored (bounce).
  - On the cycle the counter equals T_LOCK: if pin_s=0 -> DOWN, Key_Press=1 for the next cycle, Key_Level=1, hold counter cleared.
  - If pin_s=1 at that point (tap shorter than lockout or glitch) -> IDLE with no pulses.
- DOWN:
  - Hold counter increments and saturates at T_LONG.
  - On reaching T_LONG, Key_Long=1 for exactly one cycle. No repeat until the next press.
  - L2H_Sig=1 -> LOCK_UP, lock counter cleared. H2L ignored.
- LOCK_UP:
  - Lock counter increments. Edges are ignored. The hold counter keeps running and can still fire Key_Long.
  - At T_LOCK: if pin_s=1 -> IDLE, Key_Release=1 for one cycle, Key_Level=0.
  - If pin_s=0 (release glitch) -> DOWN with no pulse. Key_Level stays 1 and the hold counter is not reset.
- Latency:
  - Key_Press rises exactly T_LOCK+2 CLK cycles after the cycle in which H2L_Sig was high.
  - Key_Release has the same latency relative to L2H_Sig.
- Simultaneous H2L_Sig and L2H_Sig: only the edge relevant to the current state is acted on; the other is dropped. Both ignored in the LOCK states.
- Key_Press, Key_Release and Key_Long are never high together in one cycle, except that Key_Long may coincide with nothing else by construction of the saturation.
- Counter widths: 19 bits lock, 26 bits hold. Parameters must fit these widths. Terminal compare is equality, no wrap.
- Reset mid-lockout or mid-hold: immediate return to IDLE, all outputs 0. No pulse is emitted on reset release.
- Illegal state encoding -> IDLE.

Decomposition:
- Shared include key_defs.vh holds:
  - state encodings (2-bit: IDLE=0, LOCK_DN=1, DOWN=2, LOCK_UP=3);
  - the default T_LOCK/T_LONG constants at 50 MHz.
- One sub-module is natural: key_sync_2ff, the 2-flop synchroniser for Pin_In with reset value parameter.
- The FSM and counters stay in key_debounce_fsm.

Test Plan:
All scenarios run with T_LOCK=9, T_LONG=49.
1. Clean press: Pin_In 1->0, H2L pulse at cycle 10 -> Key_Press high at cycle 21 only; Key_Level=1 from cycle 21.
2. Bouncy press: 4 extra H2L/L2H pulses within 8 cycles after the first H2L -> exactly one Key_Press at first H2L+11; no Key_Release.
3. Short tap: press then release 5 cycles later -> no Key_Press, no Key_Release, state back to IDLE, Key_Level=0.
4. Long hold: press held 100 cycles -> Key_Press once; Key_Long once, 50 cycles after Key_Press; release -> Key_Release at L2H+11.
5. Release glitch: in DOWN, L2H pulse then Pin_In low again within 4 cycles -> no Key_Release; Key_Level stays 1.
6. Reset mid-lockout: RST asserted asynchronously 5 cycles into LOCK_DN -> all outputs 0 immediately; no Key_Press after RST deasserts without a new H2L.

Source files
------------

// File: rtl/key_debounce_fsm_pkg.sv
// Shared definitions for the key debouncer: state encodings, counter widths
// and the default 50 MHz timing constants.
package key_debounce_fsm_pkg;

    localparam int LOCK_W = 19;
    localparam int HOLD_W = 26;

    localparam logic [LOCK_W-1:0] T_LOCK_DEF = 19'd499_999;     // 10 ms at 50 MHz
    localparam logic [HOLD_W-1:0] T_LONG_DEF = 26'd49_999_999;  // 1 s at 50 MHz

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_LOCK_UP = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input, with a configurable
// reset value so an idle-high pin does not look pressed out of reset.
module key_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/key_debounce_fsm.sv
// Key debouncer: locks out edge pulses for T_LOCK+1 cycles after each edge,
// confirms against the synchronised pin and emits registered press/release/long pulses.
module key_debounce_fsm
    import key_debounce_fsm_pkg::*;
#(
    parameter logic [LOCK_W-1:0] T_LOCK = T_LOCK_DEF,
    parameter logic [HOLD_W-1:0] T_LONG = T_LONG_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    input  logic Pin_In,
    output logic Key_Press,
    output logic Key_Release,
    output logic Key_Long,
    output logic Key_Level
);

    logic pin_s;

    key_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (Pin_In),
        .q   (pin_s)
    );

    key_state_e        state_d, state_q;
    logic [LOCK_W-1:0] lock_cnt_d, lock_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
    logic              long_done_d, long_done_q;
    logic              press_d, press_q;
    logic              release_d, release_q;
    logic              long_d, long_q;
    logic              level_d, level_q;
    logic              lock_end;

    assign lock_end = (lock_cnt_q == T_LOCK);

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        level_d     = level_q;

        // Hold timer runs for the whole press, including the release lockout.
        if (state_q == ST_DOWN || state_q == ST_LOCK_UP) begin
            if (hold_cnt_q != T_LONG) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else if (!long_done_q) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (H2L_Sig) begin
                    state_d    = ST_LOCK_DN;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCK_DN: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (lock_end) begin
                    if (!pin_s) begin
                        state_d     = ST_DOWN;
                        press_d     = 1'b1;
                        level_d     = 1'b1;
                        hold_cnt_d  = '0;
                        long_done_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOWN: begin
                if (L2H_Sig) begin
                    state_d    = ST_LOCK_UP;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCK_UP: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (lock_end) begin
                    if (pin_s) begin
                        // A long pulse landing on the release cycle is dropped
                        // so release never shares a cycle with it.
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                        long_d    = 1'b0;
                        level_d   = 1'b0;
                    end else begin
                        state_d = ST_DOWN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            level_q     <= level_d;
        end
    end

    assign Key_Press   = press_q;
    assign Key_Release = release_q;
    assign Key_Long    = long_q;
    assign Key_Level   = level_q;

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Directed bench for key_debounce_fsm with T_LOCK=9, T_LONG=49: a vector
// table for press/release/long timing plus hand sequences for tap, glitch and reset.
module tb_key_debounce_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic H2L_Sig = 1'b0;
    logic L2H_Sig = 1'b0;
    logic Pin_In = 1'b1;
    logic Key_Press, Key_Release, Key_Long, Key_Level;

    int n_cmp = 0;
    int n_bad = 0;

    key_debounce_fsm #(
        .T_LOCK(19'd9),
        .T_LONG(26'd49)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .H2L_Sig     (H2L_Sig),
        .L2H_Sig     (L2H_Sig),
        .Pin_In      (Pin_In),
        .Key_Press   (Key_Press),
        .Key_Release (Key_Release),
        .Key_Long    (Key_Long),
        .Key_Level   (Key_Level)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic h2l, l2h, pin;
        logic press, rel, lng, lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input int n, input logic h, input logic l, input logic p,
                        input logic ep, input logic er, input logic el, input logic elv);
        vec_t v;
        v.h2l = h; v.l2h = l; v.pin = p;
        v.press = ep; v.rel = er; v.lng = el; v.lvl = elv;
        repeat (n) vecs.push_back(v);
    endtask

    // One row: drive inputs just after the rising edge, land on the falling edge.
    task automatic cyc(input logic h, input logic l, input logic p);
        @(posedge CLK);
        #1;
        H2L_Sig = h;
        L2H_Sig = l;
        Pin_In  = p;
        @(negedge CLK);
    endtask

    task automatic check1(input string name, input string sig, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0b expected %0b", name, sig, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic ep, input logic er,
                       input logic el, input logic elv);
        check1(name, "Key_Press",   Key_Press,   ep);
        check1(name, "Key_Release", Key_Release, er);
        check1(name, "Key_Long",    Key_Long,    el);
        check1(name, "Key_Level",   Key_Level,   elv);
    endtask

    initial begin
        // Clean press at row 10 (H2L and L2H together in IDLE: H2L wins later),
        // press at row 21, release with H2L+L2H in DOWN at row 30, release at 41.
        push(10, 0,0,1, 0,0,0,0);
        push(1,  1,0,0, 0,0,0,0);
        push(10, 0,0,0, 0,0,0,0);
        push(1,  0,0,0, 1,0,0,1);
        push(8,  0,0,0, 0,0,0,1);
        push(1,  1,1,1, 0,0,0,1);
        push(10, 0,0,1, 0,0,0,1);
        push(1,  0,0,1, 0,1,0,0);
        push(5,  0,0,1, 0,0,0,0);
        // Bouncy press then 100-cycle hold: press at b+11, long at b+61, release at b+111.
        push(1,  1,1,0, 0,0,0,0);
        push(1,  0,1,1, 0,0,0,0);
        push(1,  1,0,0, 0,0,0,0);
        push(1,  0,1,1, 0,0,0,0);
        push(1,  1,0,0, 0,0,0,0);
        push(6,  0,0,0, 0,0,0,0);
        push(1,  0,0,0, 1,0,0,1);
        push(49, 0,0,0, 0,0,0,1);
        push(1,  0,0,0, 0,0,1,1);
        push(38, 0,0,0, 0,0,0,1);
        push(1,  0,1,1, 0,0,0,1);
        push(10, 0,0,1, 0,0,0,1);
        push(1,  0,0,1, 0,1,0,0);
        push(5,  0,0,1, 0,0,0,0);

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset", 0, 0, 0, 0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].h2l, vecs[i].l2h, vecs[i].pin);
            chk($sformatf("vec%0d", i), vecs[i].press, vecs[i].rel, vecs[i].lng, vecs[i].lvl);
        end

        // Short tap: pin released before the lockout ends, nothing emitted.
        cyc(1, 0, 0);
        chk("tap0", 0, 0, 0, 0);
        for (int i = 1; i < 5; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("tap%0d", i), 0, 0, 0, 0);
        end
        cyc(0, 1, 1);
        chk("tap5", 0, 0, 0, 0);
        for (int i = 6; i < 18; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("tap%0d", i), 0, 0, 0, 0);
        end

        // Fresh press proves the tap left the FSM in IDLE, then a release glitch.
        cyc(1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("gpress%0d", i), 0, 0, 0, 0);
        end
        cyc(0, 0, 0);
        chk("gpress11", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("gdown%0d", i), 0, 0, 0, 1);
        end
        cyc(0, 1, 1);
        chk("glitch0", 0, 0, 0, 1);
        cyc(0, 0, 1);
        chk("glitch1", 0, 0, 0, 1);
        for (int i = 2; i < 22; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("glitch%0d", i), 0, 0, 0, 1);
        end

        // Asynchronous reset while held down: level must drop before any edge.
        @(posedge CLK);
        #3;
        RST    = 1'b1;
        Pin_In = 1'b1;
        #1;
        chk("rst_hold", 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Asynchronous reset mid-lockout, then pin low with no new edge pulse.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("rlock%0d", i), 0, 0, 0, 0);
        end
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("rst_lock", 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("post_rst%0d", i), 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
